wb_master_port: RTL and testbench

//  Wishbone B4 pipelined initiator: turns a single-command valid/ready request into one bus cycle.

---
 rtl/wb_master_port.sv | 243 ++++++++++++++++++++++++
 tb/tb_wb_master_port.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_port.sv
// wb_master_port: Wishbone B4 pipelined initiator.
// Turns one valid/ready command into exactly one single-beat bus cycle and
// returns the slave's ack/err as a one-cycle response pulse. Only one
// transfer is ever outstanding.
// Optional feature macro: WB_MASTER_TIMEOUT_EN. When defined, a bus cycle
// that has not completed after TIMEOUT_CYCLES cycles in REQ+WAIT is aborted
// and reported as an error with rsp_timeout set.
module wb_master_port #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int SEL_WIDTH     = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_dat,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    // response side
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // Wishbone initiator
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i
);

    // The abort path needs at least one REQ and one WAIT cycle to make sense.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_master_port: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;

    logic accept;
    logic bus_done;
    logic timeout_hit;

    // Ready only in IDLE; reset blocks a handshake that would be lost anyway.
    assign cmd_ready = (state_q == S_IDLE) && !rst_i;
    assign accept    = cmd_valid && cmd_ready;
    // ack and err together are treated as an error completion.
    assign bus_done  = ack_i || err_i;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    // Bus-cycle age: cleared on accept, counts every REQ/WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q != S_IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Abort on the edge where the age reaches the limit.
    assign timeout_hit = (state_q != S_IDLE) && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

    // Timeout counter and sticky timeout flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> REQ on accept, REQ -> WAIT once not stalled,
    // WAIT -> IDLE on ack/err; timeout abandons either busy state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ: begin
                if (timeout_hit) begin
                    state_d = S_IDLE;
                end else if (!stall_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: if (bus_done || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: bus signals and response, all registered. Bus address/
    // data/select hold their last value while idle.
    always_comb begin
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = cmd_we;
                    adr_d = cmd_adr;
                    dat_d = cmd_dat;
                    sel_d = cmd_sel;
                end
            end
            S_REQ: begin
                // ack/err are not looked at until the request is taken.
                if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b1;
`endif
                end else if (!stall_i) begin
                    stb_d = 1'b0;
                end
            end
            S_WAIT: begin
                // A real completion on the timeout edge takes priority.
                if (bus_done) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_i;
                    rsp_dat_d   = we_q ? '0 : dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b1;
`endif
                end
            end
            default: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
            end
        endcase
    end

    // Bus and response registers; reset drops any cycle in flight silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cyc_o     = cyc_q;
    assign stb_o     = stb_q;
    assign we_o      = we_q;
    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign sel_o     = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Bench for wb_master_port: table of single transfers with a scripted slave,
// plus hand sequences for reset-in-flight, back-to-back commands and timeout.
// Responses are checked by a scoreboard of expected results.
module tb_wb_master_port;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic          stall_i = 1'b0;

    wb_master_port #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i),
        .err_i(err_i), .stall_i(stall_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        err;
        logic        to;
        logic        chk_dat;
        logic [31:0] dat;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          stall;
        int          waitc;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    function automatic vec_t mk(string nm, logic we, logic [15:0] adr, logic [31:0] dat,
                                logic [3:0] sel, int stall, int waitc, logic ack, logic err,
                                logic [31:0] rdata, logic exp_err, logic [31:0] exp_dat);
        vec_t v;
        v.name = nm; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
        v.stall = stall; v.waitc = waitc; v.ack = ack; v.err = err; v.rdata = rdata;
        v.exp_err = exp_err; v.exp_dat = exp_dat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push(input logic err, input logic to, input logic chk_dat,
                        input logic [31:0] dat, input int cyc);
        exp_t e;
        e.err = err; e.to = to; e.chk_dat = chk_dat; e.dat = dat; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Response monitor: every pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_timeout", rsp_timeout, e.to);
                if (e.chk_dat) chk("rsp_dat", rsp_dat, e.dat);
                chk("rsp_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    // One command through a scripted slave: stall for v.stall REQ cycles,
    // hold off ack for v.waitc WAIT cycles, then answer with ack/err.
    task automatic run_vec(input vec_t v);
        int acc;
        int n;
        cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
        cmd_valid = 1'b1;
        chk({v.name, "_ready"}, cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        acc = cyc_cnt;
        push(v.exp_err, 1'b0, 1'b1, v.exp_dat, acc + 2 + v.stall + v.waitc);
        n = 0;
        while (stb_o && n < 50) begin
            chk({v.name, "_adr"}, adr_o, v.adr);
            chk({v.name, "_we"},  we_o,  v.we);
            chk({v.name, "_dat"}, dat_o, v.dat);
            chk({v.name, "_sel"}, sel_o, v.sel);
            chk({v.name, "_cyc"}, cyc_o, 1);
            stall_i = (n < v.stall);
            step();
            n++;
        end
        stall_i = 1'b0;
        chk({v.name, "_stb_cycles"}, n, v.stall + 1);
        for (int i = 0; i < v.waitc; i++) begin
            chk({v.name, "_wait_cyc"}, cyc_o, 1);
            chk({v.name, "_wait_stb"}, stb_o, 0);
            step();
        end
        chk({v.name, "_cyc_before_ack"}, cyc_o, 1);
        ack_i = v.ack; err_i = v.err; dat_i = v.rdata;
        step();
        ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        chk({v.name, "_cyc_drop"}, cyc_o, 0);
        chk({v.name, "_ready_after"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t post;
        int   acc, prev, n;

        vecs[0] = mk("wr_basic", 1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 32'h0,        0, 32'h0);
        vecs[1] = mk("rd_stall", 0, 16'h0010, 32'h0,        4'hF, 3, 0, 1, 0, 32'h12345678, 0, 32'h12345678);
        vecs[2] = mk("rd_wait",  0, 16'h0022, 32'h0,        4'h3, 1, 2, 1, 0, 32'hCAFE0001, 0, 32'hCAFE0001);
        vecs[3] = mk("wr_late",  1, 16'h0100, 32'h01020304, 4'hC, 0, 6, 1, 0, 32'hFFFF0000, 0, 32'h0);
        vecs[4] = mk("rd_err",   0, 16'h0040, 32'h0,        4'hF, 0, 1, 0, 1, 32'h0BAD0BAD, 1, 32'h0BAD0BAD);
        vecs[5] = mk("rd_ackerr",0, 16'h0044, 32'h0,        4'hF, 2, 0, 1, 1, 32'h00C0FFEE, 1, 32'h00C0FFEE);
        post    = mk("wr_post",  1, 16'h0200, 32'hA5A5A5A5, 4'hF, 0, 0, 1, 0, 32'h0,        0, 32'h0);

        // Reset state
        @(negedge clk_i);
        step();
        chk("rst_ready_low", cmd_ready, 0);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_adr", adr_o, 0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        step();

        // Table of single transfers
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            step();
        end

        // Reset while waiting for ack: cycle is dropped with no response
        cmd_we = 1'b1; cmd_adr = 16'h0ABC; cmd_dat = 32'h55AA55AA; cmd_sel = 4'hA;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("rw_in_wait_cyc", cyc_o, 1);
        chk("rw_in_wait_stb", stb_o, 0);
        rst_i = 1'b1;
        #1;
        chk("rw_ready_in_rst", cmd_ready, 0);
        step();
        rst_i = 1'b0;
        #1;
        chk("rw_cyc", cyc_o, 0);
        chk("rw_stb", stb_o, 0);
        chk("rw_we", we_o, 0);
        chk("rw_adr", adr_o, 0);
        chk("rw_dat", dat_o, 0);
        chk("rw_sel", sel_o, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_rsp_err", rsp_err, 0);
        chk("rw_rsp_dat", rsp_dat, 0);
        chk("rw_rsp_timeout", rsp_timeout, 0);
        chk("rw_ready", cmd_ready, 1);
        step();
        step();

        // cmd_valid held high across four commands: one accept every 3 cycles
        cmd_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] rd;
            rd = 32'h000000A0 + 32'(k);
            cmd_we = (k % 2 == 0); cmd_adr = 16'h0300 + 16'(k);
            cmd_dat = 32'h11110000 + 32'(k); cmd_sel = 4'hF;
            chk("b2b_ready_idle", cmd_ready, 1);
            step();
            acc = cyc_cnt;
            if (k == 3) cmd_valid = 1'b0;
            if (k > 0) chk("b2b_gap", acc - prev, 3);
            prev = acc;
            push(1'b0, 1'b0, 1'b1, (k % 2 == 0) ? 32'h0 : rd, acc + 2);
            chk("b2b_ready_req", cmd_ready, 0);
            chk("b2b_stb", stb_o, 1);
            step();
            chk("b2b_ready_wait", cmd_ready, 0);
            ack_i = 1'b1; dat_i = rd;
            step();
            ack_i = 1'b0; dat_i = '0;
        end
        step();

`ifdef WB_MASTER_TIMEOUT_EN
        // Slave never answers: abort after TO bus cycles
        cmd_we = 1'b0; cmd_adr = 16'h0F00; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        acc = cyc_cnt;
        push(1'b1, 1'b1, 1'b0, 32'h0, acc + TO);
        n = 0;
        while (cyc_o && n < 100) begin
            n++;
            step();
        end
        chk("to_bus_cycles", n, TO);
        chk("to_stb", stb_o, 0);
        chk("to_ready", cmd_ready, 1);
        step();
`else
        // Without the timeout the block waits indefinitely
        cmd_we = 1'b0; cmd_adr = 16'h0F00; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (40) step();
        chk("noto_cyc_held", cyc_o, 1);
        chk("noto_ready", cmd_ready, 0);
        chk("noto_rsp_timeout", rsp_timeout, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk("noto_cyc_after_rst", cyc_o, 0);
        step();
`endif
        run_vec(post);
        step();
        step();

        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
